// File: rtl/serial_subtractor_if.sv
// Handshake and result bundle for the bit-serial subtractor.
// Start/A/B/Bin flow into the block; Diff/Borrow/Busy/Done and the FSM state flow out.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             Start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic [WIDTH-1:0] Diff;
  logic             Borrow;
  logic             Busy;
  logic             Done;
  logic [1:0]       State;

  modport master (
    output Start, A, B, Bin,
    input  Diff, Borrow, Busy, Done, State
  );

  modport slave (
    input  Start, A, B, Bin,
    output Diff, Borrow, Busy, Done, State
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: A - B - Bin using one full-subtractor cell,
// one borrow flop and right-shifting operand/result registers, LSB first.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input logic              Clk,
  input logic              Reset_n,
  serial_subtractor_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   res_q;
  logic               br_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   diff_q;
  logic               borrow_q;
  logic               busy_q;
  logic               done_q;

  logic               bit_d;
  logic               bo_d;
  logic [WIDTH-1:0]   res_d;
  logic               last_bit;

  // Full-subtractor cell on the current LSBs and the running borrow.
  assign bit_d    = a_q[0] ^ b_q[0] ^ br_q;
  assign bo_d     = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  assign res_d    = {bit_d, res_q[WIDTH-1:1]};
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  // Handshake: Start is accepted on an edge where the FSM is in IDLE or DONE;
  // Busy is high from the accepting edge until the completion edge, where Done
  // pulses for one cycle and Diff/Borrow update. Start while busy is ignored.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.Start) begin
            a_q     <= bus.A;
            b_q     <= bus.B;
            br_q    <= bus.Bin;
            res_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          br_q  <= bo_d;
          res_q <= res_d;
          cnt_q <= cnt_q + 1'b1;
          if (last_bit) begin
            diff_q   <= res_d;
            borrow_q <= bo_d;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.Diff   = diff_q;
  assign bus.Borrow = borrow_q;
  assign bus.Busy   = busy_q;
  assign bus.Done   = done_q;
  assign bus.State  = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive bench for serial_subtractor (WIDTH=4) plus a WIDTH=8 random regression.
module tb_serial_subtractor;

  localparam int W  = 4;
  localparam int W8 = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W))  bus4 ();
  serial_subtractor_if #(.WIDTH(W8)) bus8 ();

  serial_subtractor #(.WIDTH(W)) u_dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus4)
  );

  serial_subtractor #(.WIDTH(W8)) u_dut8 (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus8)
  );

  // ---------------- scoreboard ----------------
  int              n_vec = 0;
  int              n_bad = 0;
  logic [W:0]      exp_q[$];
  logic [W8:0]     exp8_q[$];
  logic [W-1:0]    hold_diff;
  logic            hold_borrow;
  logic [W8-1:0]   hold_diff8;
  logic [W:0]      exp_res;
  logic [W8:0]     exp_res8;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic do_op4(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    logic [W:0] e;
    e = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    exp_q.push_back(e);
    bus4.Start = 1'b1; bus4.A = a; bus4.B = b; bus4.Bin = bin;
    tick();
    bus4.Start = 1'b0;
    bus4.A = W'($urandom); bus4.B = W'($urandom); bus4.Bin = 1'($urandom);
    check_eq("busy_on_accept", 32'(bus4.Busy), 32'd1);
    check_eq("no_done_on_accept", 32'(bus4.Done), 32'd0);
    for (int i = 1; i <= W; i++) begin
      tick();
      if (i < W) begin
        check_eq("busy_shift", 32'(bus4.Busy), 32'd1);
        check_eq("done_shift", 32'(bus4.Done), 32'd0);
        check_eq("diff_hold", 32'(bus4.Diff), 32'(hold_diff));
        check_eq("borrow_hold", 32'(bus4.Borrow), 32'(hold_borrow));
      end else begin
        check_eq("done_pulse", 32'(bus4.Done), 32'd1);
        check_eq("busy_end", 32'(bus4.Busy), 32'd0);
        exp_res = exp_q.pop_front();
        check_eq("result", 32'({bus4.Borrow, bus4.Diff}), 32'(exp_res));
        {hold_borrow, hold_diff} = exp_res;
      end
    end
    tick();
    check_eq("done_falls", 32'(bus4.Done), 32'd0);
    check_eq("idle_state", 32'(bus4.State), 32'd0);
  endtask

  task automatic do_op8(input logic [W8-1:0] a, input logic [W8-1:0] b, input logic bin);
    exp8_q.push_back({1'b0, a} - {1'b0, b} - {{W8{1'b0}}, bin});
    bus8.Start = 1'b1; bus8.A = a; bus8.B = b; bus8.Bin = bin;
    tick();
    bus8.Start = 1'b0;
    bus8.A = W8'($urandom); bus8.B = W8'($urandom);
    check_eq("w8_diff_hold", 32'(bus8.Diff), 32'(hold_diff8));
    for (int i = 0; i < W8 + 2 && !bus8.Done; i++) tick();
    if (!bus8.Done) begin
      check_eq("w8_timeout", 32'd0, 32'd1);
      void'(exp8_q.pop_front());
    end else begin
      exp_res8 = exp8_q.pop_front();
      check_eq("w8_result", 32'({bus8.Borrow, bus8.Diff}), 32'(exp_res8));
      hold_diff8 = exp_res8[W8-1:0];
    end
    tick();
  endtask

  // ---------------- stimulus ----------------
  logic done_edge;

  initial begin
    bus4.Start = 1'b0; bus4.A = '0; bus4.B = '0; bus4.Bin = 1'b0;
    bus8.Start = 1'b0; bus8.A = '0; bus8.B = '0; bus8.Bin = 1'b0;
    hold_diff = '0; hold_borrow = 1'b0; hold_diff8 = '0;
    rst_n = 1'b0;
    #12;
    check_eq("rst_diff", 32'(bus4.Diff), 32'd0);
    check_eq("rst_borrow", 32'(bus4.Borrow), 32'd0);
    check_eq("rst_busy", 32'(bus4.Busy), 32'd0);
    check_eq("rst_done", 32'(bus4.Done), 32'd0);
    check_eq("rst_state", 32'(bus4.State), 32'd0);
    rst_n = 1'b1;
    tick();

    // directed vectors
    do_op4(4'd9,  4'd5,  1'b0);   // 4, no borrow
    do_op4(4'd5,  4'd9,  1'b0);   // 0xC, borrow
    do_op4(4'd0,  4'd0,  1'b1);   // 0xF, borrow
    do_op4(4'd15, 4'd15, 1'b0);   // 0, no borrow
    do_op4(4'd15, 4'd0,  1'b1);   // 0xE, no borrow
    do_op4(4'd3,  4'd3,  1'b1);   // 0xF, borrow

    // Start during SHIFT is ignored
    bus4.Start = 1'b1; bus4.A = 4'd9; bus4.B = 4'd5; bus4.Bin = 1'b0;
    tick();
    bus4.Start = 1'b0;
    tick();
    bus4.Start = 1'b1; bus4.A = 4'd1; bus4.B = 4'd2; bus4.Bin = 1'b1;
    tick();
    bus4.Start = 1'b0;
    check_eq("ign_busy", 32'(bus4.Busy), 32'd1);
    tick();
    tick();
    check_eq("ign_done", 32'(bus4.Done), 32'd1);
    check_eq("ign_result", 32'({bus4.Borrow, bus4.Diff}), 32'h04);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("ign_no_second_done", 32'(bus4.Done), 32'd0);
      check_eq("ign_idle_busy", 32'(bus4.Busy), 32'd0);
    end

    // Start held high: back-to-back operations
    bus4.Start = 1'b1; bus4.A = 4'd7; bus4.B = 4'd3; bus4.Bin = 1'b1;
    for (int e = 0; e <= 14; e++) begin
      tick();
      done_edge = (e == 4) || (e == 9) || (e == 14);
      check_eq("b2b_done", 32'(bus4.Done), 32'(done_edge));
      check_eq("b2b_busy", 32'(bus4.Busy), 32'(!done_edge));
      if (done_edge) check_eq("b2b_result", 32'({bus4.Borrow, bus4.Diff}), 32'h03);
    end
    bus4.Start = 1'b0;
    tick();
    hold_diff = 4'd3; hold_borrow = 1'b0;

    // asynchronous reset mid-operation
    bus4.Start = 1'b1; bus4.A = 4'd9; bus4.B = 4'd5; bus4.Bin = 1'b0;
    tick();
    bus4.Start = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_diff", 32'(bus4.Diff), 32'd0);
    check_eq("arst_busy", 32'(bus4.Busy), 32'd0);
    check_eq("arst_done", 32'(bus4.Done), 32'd0);
    check_eq("arst_state", 32'(bus4.State), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("arst_no_done", 32'(bus4.Done), 32'd0);
      check_eq("arst_no_busy", 32'(bus4.Busy), 32'd0);
    end
    hold_diff = '0; hold_borrow = 1'b0; hold_diff8 = '0;
    do_op4(4'd9, 4'd5, 1'b0);

    // exhaustive WIDTH=4 sweep
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          do_op4(W'(a), W'(b), 1'(c));

    // WIDTH=8 directed corners and random regression
    do_op8(8'd0,   8'd0,   1'b1);
    do_op8(8'd255, 8'd255, 1'b0);
    do_op8(8'd200, 8'd57,  1'b1);
    for (int i = 0; i < 40; i++)
      do_op8(W8'($urandom_range(0, 255)), W8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor; the subtraction counterpart to the team's ripple-carry parallel adder.
- Computes A − B − Bin with a single full-subtractor cell and one borrow flop, one bit per clock, LSB first.
- Sits in the arithmetic library as the area-cheap sequential alternative.
- Operands are captured by a Start/Busy/Done handshake; results are held stable until the next operation completes.

Parameters:
- WIDTH, 4, operand and difference width in bits; legal range 2 to 16.

Ports:
- Clk  input  1  rising-edge clock
- Reset_n  input  1  asynchronous active-low reset
- Start  input  1  request a subtraction; sampled on Clk rising edge
- A  input  WIDTH  minuend; sampled only on an accepted Start
- B  input  WIDTH  subtrahend; sampled only on an accepted Start
- Bin  input  1  borrow-in; sampled only on an accepted Start
- Diff  output  WIDTH  registered difference
- Borrow  output  1  registered borrow-out
- Busy  output  1  operation in progress
- Done  output  1  one-cycle pulse: Diff and Borrow just updated

Behaviour:
- Interface: one clock (Clk); reset is asynchronous and active-low (Reset_n).
- Reset (asynchronous, any time, including mid-operation):
  - State goes to IDLE.
  - Diff=0, Borrow=0, Busy=0, Done=0.
  - Internal shift registers, borrow flop and bit counter are cleared.
  - Any in-flight operation is discarded; no Done is produced.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - Start=1 at edge k: latch A and B into operand shift registers and Bin into the borrow flop; clear the counter; go to SHIFT; Busy=1 from edge k.
  - Start=0: remain in IDLE.
- SHIFT, one bit per edge (edges k+1 .. k+WIDTH):
  - a = operand A LSB, b = operand B LSB, br = borrow flop.
  - d = a ^ b ^ br.
  - bo = (~a & b) | (~(a ^ b) & br).
  - Shift d into the MSB of the internal result register (right shift); shift both operand registers right; borrow flop <= bo; counter increments.
  - Final edge k+WIDTH: Diff <= completed result, Borrow <= bo, Done <= 1, Busy <= 0, go to DONE.
- DONE (one cycle):
  - Done=1 for exactly this one cycle, then returns to 0.
  - Start=1: accepted as from IDLE; Done falls and Busy rises on that same edge.
  - Start=0: go to IDLE.
- Latency: Start accepted at edge k gives results valid and Done=1 after edge k+WIDTH. Throughput is one operation per WIDTH+1 cycles.
- Start while Busy=1 (IDLE-to-SHIFT edge excluded) is ignored, with no effect on the operation in flight.
- Diff and Borrow change only on the completion edge or on reset. They hold the previous result throughout SHIFT.
- A, B and Bin may change freely after the accepting edge without affecting the result.
- Arithmetic contract:
  - {Borrow, Diff} = ({1'b0,A} − {1'b0,B} − Bin) mod 2^(WIDTH+1).
  - Borrow=1 iff A < B + Bin (unsigned).
  - Diff wraps modulo 2^WIDTH.
- Counter is ceil(log2(WIDTH+1)) bits. There is no overflow path: it is cleared on every accept.

Test Plan:
- Reset, then A=9, B=5, Bin=0, Start pulsed at edge 0 -> Busy high edges 0–3; Done=1 after edge 4 only; Diff=4, Borrow=0.
- A=5, B=9, Bin=0 -> Diff=12 (0xC), Borrow=1. Then A=0, B=0, Bin=1 -> Diff=15, Borrow=1. Then A=15, B=15, Bin=0 -> Diff=0, Borrow=0. Diff holds the prior value during each SHIFT.
- Accept A=9, B=5, then Start=1 with A=1, B=2 at edge 2 -> ignored; result Diff=4, Borrow=0 at edge 4; no second Done.
- Start held high continuously with A=7, B=3, Bin=1 -> Done at edges 4, 9, 14; each result Diff=3, Borrow=0; Busy low only at edges 4, 9, 14.
- Accept A=9, B=5, assert Reset_n=0 between edges 2 and 3 -> outputs 0 immediately; no Done after release. A new Start then yields the correct result.
- Exhaustive sweep (WIDTH=4): all 512 A/B/Bin combinations -> {Borrow, Diff} matches the arithmetic contract; also run WIDTH=8 random regression.
